// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the writable VGA frame buffer.
// VGA_FB_DBUF_EN adds a bank-select bit to the RAM address for double buffering.
package vga_fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int PIX_W_DEF = 24;

`ifdef VGA_FB_DBUF_EN
    localparam int BANK_W = 1;
`else
    localparam int BANK_W = 0;
`endif

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] fb_w);
        return y * fb_w + x;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// With VGA_FB_DBUF_EN the address MSB selects one of two equal banks.
module vga_fb_ram
    import vga_fb_pkg::*;
#(
    parameter int DW    = PIX_W_DEF,
    parameter int AW    = 19,
    parameter int DEPTH = 307200
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW+BANK_W-1:0] waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [AW+BANK_W-1:0] raddr,
    output logic [DW-1:0]        rdata
);

    localparam int IW    = AW + BANK_W;
    localparam int WORDS = DEPTH << BANK_W;

    logic [DW-1:0] mem [WORDS];

    // Bank 1 is stacked directly on top of bank 0, so no storage is wasted
    // when DEPTH is not a power of two.
    function automatic logic [IW-1:0] phys(input logic [IW-1:0] a);
`ifdef VGA_FB_DBUF_EN
        return a[IW-1] ? IW'(DEPTH) + {1'b0, a[IW-2:0]} : {1'b0, a[IW-2:0]};
`else
        return a;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[phys(waddr)] <= wdata;
        end
        rdata <= mem[phys(raddr)];
    end

endmodule

// File: rtl/vga_fb.sv
// Writable frame buffer behind vga_ctrl: scan-driven read, host write port, vsync-aligned swap.
// Define VGA_FB_DBUF_EN for two buffers (display front, write back, swap at frame_start).
module vga_fb
    import vga_fb_pkg::*;
#(
    parameter  int H_RES    = H_RES_DEF,
    parameter  int V_RES    = V_RES_DEF,
    parameter  int PIX_W    = PIX_W_DEF,
    parameter  int SCALE_SH = 0,
    localparam int FB_W     = H_RES >> SCALE_SH,
    localparam int FB_H     = V_RES >> SCALE_SH,
    localparam int FB_AW    = $clog2(FB_W * FB_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_addr,
    input  logic [9:0]       v_addr,
    input  logic             valid,
    input  logic             frame_start,
    output logic [PIX_W-1:0] vga_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_oor,
    input  logic             swap_req,
    output logic             swap_done
);

    localparam int               FB_SIZE = FB_W * FB_H;
    localparam logic [FB_AW:0]   FB_LIM  = (FB_AW + 1)'(FB_SIZE);
    localparam logic [10:0]      H_LIM   = 11'(H_RES);
    localparam logic [10:0]      V_LIM   = 11'(V_RES);

    swap_state_t             state;
    swap_state_t             state_nxt;
    logic                    swap_fire;
    logic                    wr_fire;
    logic                    wr_in_range;
    logic                    ram_we;
    logic                    rd_ok;
    logic                    rd_ok_q;
    logic [FB_AW-1:0]        rd_idx;
    logic [PIX_W-1:0]        ram_q;
    logic [FB_AW+BANK_W-1:0] ram_waddr;
    logic [FB_AW+BANK_W-1:0] ram_raddr;

    assign rd_ok  = valid && ({1'b0, h_addr} < H_LIM) && ({1'b0, v_addr} < V_LIM);
    // Off-screen scan positions read word 0; the result is masked by rd_ok_q.
    assign rd_idx = rd_ok ? FB_AW'(fb_addr(32'(h_addr >> SCALE_SH),
                                           32'(v_addr >> SCALE_SH),
                                           32'(FB_W)))
                          : '0;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < FB_LIM;
    // wr_ready reads high during reset, but nothing may land in the RAM then.
    assign ram_we      = wr_fire && wr_in_range && rst;

`ifdef VGA_FB_DBUF_EN
    logic front;

    assign wr_ready  = (state == IDLE);
    assign ram_waddr = {~front, wr_addr};
    assign ram_raddr = {front, rd_idx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front <= 1'b0;
        end else if (swap_fire) begin
            front <= ~front;
        end
    end
`else
    assign wr_ready  = 1'b1;
    assign ram_waddr = wr_addr;
    assign ram_raddr = rd_idx;
`endif

    // A request seen in IDLE only arms the FSM, so a coincident frame_start
    // is never the one that completes it.
    always_comb begin
        state_nxt = state;
        swap_fire = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_nxt = IDLE;
                    swap_fire = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_ok_q   <= 1'b0;
            wr_oor    <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_ok_q   <= rd_ok;
            wr_oor    <= wr_fire && !wr_in_range;
            swap_done <= swap_fire;
        end
    end

    vga_fb_ram #(
        .DW   (PIX_W),
        .AW   (FB_AW),
        .DEPTH(FB_SIZE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(wr_data),
        .raddr(ram_raddr),
        .rdata(ram_q)
    );

    assign vga_data = rd_ok_q ? ram_q : '0;

endmodule
